lattice_pipe_ctrl: RTL and testbench
====================================

Name: lattice_pipe_ctrl

Overview:
- Elastic pipeline controller that sequences a chain of STAGES vector delay elements (REG_WIDTH x VECTOR lanes each) in the DSP lattice datapath.
- Tracks per-stage valid and last flags and generates a per-stage load enable for each delay element.
- Applies valid/ready handshakes on the sample input and output, and clears lattice state between frames.
- Owns no sample data: data registers stay in the delay elements, which load on stage_en[i].

Parameters:
- STAGES, 4, number of delay-element stages sequenced (must be >= 2)
- FCNT_W, 8, width of the completed-frame counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream sample vector valid
- in_last  input  1  qualifies the final sample of a frame; sampled only on an input handshake
- in_ready  output  1  controller accepts a sample this cycle
- out_valid  output  1  stage STAGES-1 holds a valid sample
- out_last  output  1  the sample in stage STAGES-1 is a frame's last
- out_ready  input  1  downstream accepts
- stage_en  output  STAGES  load enable for delay element i; element 0 loads from the input
- stage_clr  output  1  one-cycle synchronous clear of all delay-element state
- busy  output  1  high in any state other than IDLE
- frame_cnt  output  FCNT_W  count of fully drained frames

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - v[], l[], frame_cnt and the FSM are cleared; FSM enters IDLE.
  - stage_clr=0; out_valid, out_last and busy are 0.
  - stage_en and in_ready are forced to 0 while rst_n=0.
  - Reset mid-frame discards all in-flight samples. No stage_clr is issued; the datapath owner resets the delay elements.
- Stage enables, combinational:
  - en[STAGES-1] = !v[STAGES-1] | out_ready
  - en[i] = !v[i] | en[i+1]
  - stage_en = en, forced to 0 in CLEAR.
  - Bubbles collapse: an empty stage always loads.
  - The combinational out_ready -> in_ready chain is intentional. There is no skid buffer.
- Handshakes:
  - acc = in_valid & in_ready
  - in_ready = en[0] & (state==IDLE | state==RUN)
  - On en[0]: v[0] <= acc and l[0] <= acc & in_last.
  - On en[i], i>0: v[i] <= v[i-1] and l[i] <= l[i-1].
  - out_valid = v[STAGES-1]; out_last = l[STAGES-1].
  - The output transfer occurs when out_valid & out_ready.
- Latency: a sample accepted at edge t sets out_valid after edge t+STAGES-1, i.e. visible in cycle t+STAGES. Stalls add one cycle each. Throughput is 1 sample/cycle with out_ready held high.
- FSM states: IDLE, RUN, DRAIN, CLEAR.
  - IDLE -> RUN on acc & !in_last.
  - IDLE -> DRAIN on acc & in_last (single-sample frame).
  - RUN -> DRAIN on acc & in_last.
  - DRAIN: in_ready=0. On an output transfer with out_last=1, go to CLEAR.
  - CLEAR lasts exactly one cycle:
    - stage_clr=1, stage_en=0, in_ready=0.
    - frame_cnt increments, wrapping at 2^FCNT_W.
    - Next state is IDLE.
- Boundary rules:
  - in_last without in_valid is ignored.
  - out_ready held low with a full pipeline gives all stage_en=0 and in_ready=0. v[] and l[] hold.
  - Only one frame is in flight at a time: a new frame is never accepted before CLEAR completes.
  - in_valid asserted during DRAIN or CLEAR is held off, not dropped.
  - frame_cnt wraps from 2^FCNT_W-1 to 0 silently.

Decomposition:
- Package lattice_pipe_pkg:
  - state enum (IDLE, RUN, DRAIN, CLEAR), 2-bit encoding
  - default constants LATTICE_STAGES=4 and LATTICE_FCNT_W=8
- Natural sub-module lattice_valid_stage:
  - one v/l flag pair with its en computation
  - chained STAGES times via a generate loop
- The FSM and frame counter stay in lattice_pipe_ctrl.

Test Plan:
1. Free-flow latency: STAGES=4, out_ready=1, accept one sample (in_last=0) at cycle 0. Required: out_valid=1 in cycle 4 only, stage_en=4'b1111 throughout, busy=1 from cycle 1.
2. Back-pressure: fill 4 samples, then hold out_ready=0 for 5 cycles. Required: stage_en=0 and in_ready=0 for those cycles, out_valid stays 1. Release: all 4 samples exit in order on consecutive cycles, with no loss or duplication.
3. Bubble collapse: accept samples at cycles 0 and 3 with out_ready=0 from cycle 2. Required: the second sample advances until adjacent to the first (v=4'b1100 after settling), then stage_en[3:2]=0 and stage_en[1:0]=2'b11.
4. Frame boundary: 3-sample frame with in_last on the 3rd, in_valid held high after it. Required:
   - in_ready=0 during DRAIN.
   - After out_last transfers: one cycle of stage_clr=1 with stage_en=0, frame_cnt 0->1, then IDLE with in_ready=1.
5. Single-sample frame and counter wrap: FCNT_W=2, run 4 frames each of one sample with in_last=1. Required: IDLE->DRAIN directly each time; frame_cnt goes 1,2,3,0.
6. Reset mid-operation: rst_n=0 for one cycle with 3 samples in flight in DRAIN. Required: next cycle out_valid=0, busy=0, frame_cnt=0, stage_clr=0, and no stale sample emerges afterwards.

Source files
------------

// File: rtl/lattice_pipe_pkg.sv
// Shared types and default sizing for the lattice pipeline controller.
package lattice_pipe_pkg;

  localparam int unsigned LATTICE_STAGES = 4;
  localparam int unsigned LATTICE_FCNT_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StClear = 2'd3
  } state_e;

endpackage

// File: rtl/lattice_valid_stage.sv
// One valid/last flag pair for a delay-element stage plus its load enable.
module lattice_valid_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic en_next,
  input  logic hold,
  input  logic v_prev,
  input  logic l_prev,
  output logic load,
  output logic v,
  output logic l
);

  logic v_q;
  logic l_q;

  // An empty stage always loads, so bubbles collapse toward the output.
  assign load = (~v_q | en_next) & ~hold;
  assign v    = v_q;
  assign l    = l_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      l_q <= 1'b0;
    end else if (load) begin
      v_q <= v_prev;
      l_q <= l_prev;
    end
  end

endmodule

// File: rtl/lattice_pipe_ctrl.sv
// Elastic pipeline controller: per-stage valid/last tracking, load enables,
// frame sequencing and inter-frame state clear for the lattice datapath.
module lattice_pipe_ctrl
  import lattice_pipe_pkg::*;
#(
  parameter int unsigned STAGES = LATTICE_STAGES,
  parameter int unsigned FCNT_W = LATTICE_FCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [STAGES-1:0] stage_en,
  output logic              stage_clr,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_e state_q, state_d;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] l;
  logic [STAGES-1:0] v_prev;
  logic [STAGES-1:0] l_prev;
  logic [STAGES-1:0] en_next;
  logic              hold;
  logic              acc;
  logic              out_xfer;
  logic [FCNT_W-1:0] frame_cnt_q;

  // Downstream enable in flattened form: stage i+1 can take a sample unless
  // every stage above i is full and the sink stalls. Same result as the
  // en[i] = !v[i] | en[i+1] ripple, without a self-referencing vector.
  always_comb begin
    logic full_above;
    full_above = 1'b1;
    en_next    = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      en_next[i] = out_ready | ~full_above;
      full_above = full_above & v[i];
    end
  end

  assign hold   = (state_q == StClear) | ~rst_n;
  assign v_prev = {v[STAGES-2:0], acc};
  assign l_prev = {l[STAGES-2:0], acc & in_last};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    lattice_valid_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_next (en_next[i]),
      .hold    (hold),
      .v_prev  (v_prev[i]),
      .l_prev  (l_prev[i]),
      .load    (stage_en[i]),
      .v       (v[i]),
      .l       (l[i])
    );
  end

  assign in_ready  = stage_en[0] & ((state_q == StIdle) | (state_q == StRun));
  assign acc       = in_valid & in_ready;
  assign out_valid = v[STAGES-1];
  assign out_last  = l[STAGES-1];
  assign out_xfer  = out_valid & out_ready;
  assign busy      = (state_q != StIdle);
  assign stage_clr = (state_q == StClear);
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (acc) state_d = in_last ? StDrain : StRun;
      end
      StRun: begin
        if (acc && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (out_xfer && out_last) state_d = StClear;
      end
      StClear: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StClear) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_lattice_pipe_ctrl.sv
// Self-checking bench for lattice_pipe_ctrl: per-cycle vector table, directed
// frame/reset sequences and a data scoreboard over a modelled delay chain.
module tb_lattice_pipe_ctrl;

  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, out_last, stage_clr, busy;
  logic [STAGES-1:0] stage_en;
  logic [7:0]        frame_cnt;

  logic              in_ready_w, out_valid_w, out_last_w, stage_clr_w, busy_w;
  logic [STAGES-1:0] stage_en_w;
  logic [1:0]        frame_cnt_w;

  int checks = 0;
  int errors = 0;

  lattice_pipe_ctrl #(.STAGES(STAGES), .FCNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .stage_en  (stage_en),
    .stage_clr (stage_clr),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for wrap checking.
  lattice_pipe_ctrl #(.STAGES(STAGES), .FCNT_W(2)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_w),
    .out_valid (out_valid_w),
    .out_last  (out_last_w),
    .out_ready (out_ready),
    .stage_en  (stage_en_w),
    .stage_clr (stage_clr_w),
    .busy      (busy_w),
    .frame_cnt (frame_cnt_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: data model of the delay elements, loaded on stage_en.
  logic [8:0]        sb_q[$];
  logic [7:0]        cur_data = 8'd0;
  logic [7:0]        dmodel[STAGES];
  logic              acc_s = 1'b0;
  logic [STAGES-1:0] en_s = '0;

  always @(negedge clk) begin
    logic [8:0] exp_e;
    acc_s = rst_n && in_valid && in_ready;
    en_s  = rst_n ? stage_en : '0;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (acc_s) sb_q.push_back({in_last, cur_data});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("sb_data", int'(dmodel[STAGES-1]), int'(exp_e[7:0]));
          chk("sb_last", int'(out_last), int'(exp_e[8]));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) dmodel[i] <= '0;
    end else begin
      if (en_s[0]) dmodel[0] <= cur_data;
      for (int i = 1; i < STAGES; i++) if (en_s[i]) dmodel[i] <= dmodel[i-1];
      if (acc_s) cur_data <= cur_data + 8'd1;
    end
  end

  typedef struct {
    logic             iv, il, ordy;
    logic             ir, ov, ol, bz, clr;
    logic [STAGES-1:0] en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, il, ordy, ir, ov, ol, bz, clr,
                              input logic [STAGES-1:0] en);
    vec_t r;
    r.iv = iv; r.il = il; r.ordy = ordy;
    r.ir = ir; r.ov = ov; r.ol = ol; r.bz = bz; r.clr = clr; r.en = en;
    return r;
  endfunction

  initial begin
    int n;
    // Free-flow latency: one sample, visible at the output 4 cycles later.
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 4'b1111));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    // Back-pressure: fill, stall 5 cycles, release.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 4'b1111));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 4'b0000));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    // Bubble collapse.
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 4'b0111));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 4'b0111));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 4'b0011));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 4'b0011));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    // Frame boundary: 3-sample frame, in_valid held high into DRAIN/CLEAR.
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 1, 0, 4'b1111));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 4'b1111));

    // Reset: enables and in_ready forced low while rst_n=0.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_stage_en", int'(stage_en), 0);
    tick();
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stage_clr", int'(stage_clr), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_frame_cnt_w", int'(frame_cnt_w), 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_last = vecs[i].il; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].ir));
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
      chk($sformatf("v%0d_out_last", i), int'(out_last), int'(vecs[i].ol));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].bz));
      chk($sformatf("v%0d_stage_clr", i), int'(stage_clr), int'(vecs[i].clr));
      chk($sformatf("v%0d_stage_en", i), int'(stage_en), int'(vecs[i].en));
      tick();
    end
    chk("frame_boundary_cnt", int'(frame_cnt), 1);
    chk("frame_boundary_cnt_w", int'(frame_cnt_w), 1);

    // Single-sample frames go IDLE->DRAIN directly; narrow counter wraps.
    for (int f = 0; f < 4; f++) begin
      in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
      #1;
      chk($sformatf("ss%0d_idle_busy", f), int'(busy), 0);
      chk($sformatf("ss%0d_idle_ready", f), int'(in_ready), 1);
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      chk($sformatf("ss%0d_drain_busy", f), int'(busy), 1);
      chk($sformatf("ss%0d_drain_ready", f), int'(in_ready), 0);
      n = 0;
      while (!stage_clr && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("ss%0d_clr_seen", f), int'(stage_clr), 1);
      chk($sformatf("ss%0d_clr_en", f), int'(stage_en), 0);
      tick();
      chk($sformatf("ss%0d_frame_cnt", f), int'(frame_cnt), 2 + f);
      chk($sformatf("ss%0d_frame_cnt_w", f), int'(frame_cnt_w), (2 + f) % 4);
    end

    // Reset mid-frame with 3 samples held in DRAIN.
    out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    tick();
    tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("mr_drain_busy", int'(busy), 1);
    chk("mr_drain_ready", int'(in_ready), 0);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("mr_rst_stage_en", int'(stage_en), 0);
    chk("mr_rst_in_ready", int'(in_ready), 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_frame_cnt", int'(frame_cnt), 0);
    chk("mr_frame_cnt_w", int'(frame_cnt_w), 0);
    chk("mr_stage_clr", int'(stage_clr), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mr_no_stale%0d", i), int'(out_valid), 0);
      tick();
    end

    // One more frame after reset, then the scoreboard must be empty.
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (busy && n < 12) begin
      tick();
      n++;
    end
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_frame_cnt", int'(frame_cnt), 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
